x86_sram_responder: RTL and testbench
=====================================

Name: x86_sram_responder

Overview:
Memory-side responder for the x86 core's byte bus (20-bit address, 8-bit data, rd/wr strobes, `locked` step-enable). It converts each core request into a timed access to an external 16-bit asynchronous SRAM, with byte-lane selection and programmable wait states. It drives `locked` as a one-cycle completion pulse that lets the core advance exactly one step per access. It sits between the core and the board SRAM pins; the tristate for the SRAM data bus lives in the top level.

Parameters:
SRAM_AW, 18, SRAM word-address width; 2^SRAM_AW x 16-bit words.
WAIT_RD, 2, cycles with sram_oe_n low per read; must be 1..15.
WAIT_WR, 2, cycles with sram_we_n low per write; must be 1..15.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous active-high reset.
address  in  20  core byte address.
o_data  in  8  core write data.
rd  in  1  core read request.
wr  in  1  core write request.
i_data  out  8  read data returned to the core; registered.
locked  out  1  completion pulse; the core executes one step on each edge where it is high.
sram_addr  out  SRAM_AW  word address = address[SRAM_AW:1].
sram_dq_i  in  16  SRAM data in (from the top-level tristate).
sram_dq_o  out  16  SRAM write data.
sram_dq_oe  out  1  top level drives sram_dq_o onto the pins when high.
sram_ce_n  out  1  chip enable, active low.
sram_oe_n  out  1  output enable, active low.
sram_we_n  out  1  write enable, active low.
sram_ub_n  out  1  upper byte lane enable, active low (odd address).
sram_lb_n  out  1  lower byte lane enable, active low (even address).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE, locked=0, i_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0.
  - All SRAM strobes high, including ce_n, ub_n, lb_n.
  - An access interrupted by reset is abandoned: no locked pulse, i_data unchanged from its reset value.
- States: IDLE, READ, WSETUP, WRITE, WHOLD, DONE. Only DONE drives locked=1.
- IDLE (locked=0, strobes inactive). Request is sampled at the end of the cycle:
  - wr=1: latch address/o_data, go to WSETUP. wr has priority over rd when both are 1.
  - else rd=1: latch address, go to READ.
  - else (neither): go to DONE. This is a null step so the core never deadlocks; i_data is held.
- Latched request drives:
  - sram_addr = addr[SRAM_AW:1]. Address bits above SRAM_AW are ignored, so addresses wrap modulo 2^(SRAM_AW+1) bytes.
  - addr[0]=0 selects lb_n=0, ub_n=1. addr[0]=1 selects ub_n=0, lb_n=1.
  - ce_n=0 in READ, WSETUP, WRITE and WHOLD.
- READ:
  - oe_n=0 for exactly WAIT_RD cycles, timed by a down-counter.
  - On the edge ending the last READ cycle, capture sram_dq_i: i_data <= addr[0] ? dq_i[15:8] : dq_i[7:0].
  - Then go to DONE.
- WSETUP: 1 cycle. dq_o={o_data,o_data}, dq_oe=1, we_n=1.
- WRITE: we_n=0 for exactly WAIT_WR cycles; dq_oe=1 and data held.
- WHOLD: 1 cycle. we_n=1, data still driven (dq_oe=1). Then go to DONE.
- DONE:
  - locked=1 for exactly one cycle, all strobes inactive, dq_oe=0. Then go to IDLE.
  - The core may change address/rd/wr on this edge; the new values are sampled in the following IDLE cycle.
- Latency, counting cycles after the IDLE sampling cycle until locked=1:
  - read: WAIT_RD+1.
  - write: WAIT_WR+3.
  - null: 1.
- Request inputs are ignored outside IDLE. The core holds them stable while locked=0.
- Bus-contention rule: oe_n=0 and dq_oe=1 are never asserted in the same cycle.
- i_data changes only on read completion and on reset.

Test Plan:
1. Reset check -> assert reset mid-stream: all outputs reach their reset values with no clock edge; locked=0, strobes high.
2. Odd-address read -> WAIT_RD=2, SRAM model word 0x00010 = 0xA55A, rd=1, address=0x00021: oe_n low 2 cycles, sram_addr=0x10, ub_n=0, then locked=1 for one cycle and i_data=0xA5 on the 3rd cycle after sampling.
3. Even-address write -> WAIT_WR=2, wr=1, address=0x00400, o_data=0x3C:
   - lb_n=0, ub_n=1, dq_o=0x3C3C.
   - Setup, then we_n low 2 cycles, then hold; locked pulses 5 cycles after sampling.
   - SRAM upper byte unchanged.
4. rd=1 and wr=1 together at address 0x00001 -> a write to the upper lane occurs and oe_n never asserts; a subsequent read of 0x00001 returns the written byte.
5. rd=0, wr=0 -> locked pulses every 2 cycles; i_data holds its last value; no SRAM strobe toggles.
6. Address wrap -> address=0xFFFFF with SRAM_AW=18: sram_addr=0x3FFFF, ub_n=0. Then reset asserted during WRITE: we_n goes high immediately and no locked pulse follows.

Source files
------------

// File: rtl/x86_sram_responder.sv
// x86_sram_responder: turns x86 core byte-bus requests into timed 16-bit async SRAM accesses with a one-cycle locked step pulse.
module x86_sram_responder #(
    parameter int SRAM_AW = 18,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [19:0]        address,
    input  logic [7:0]         o_data,
    input  logic               rd,
    input  logic               wr,
    output logic [7:0]         i_data,
    output logic               locked,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);
    typedef enum logic [2:0] {IDLE, READ, WSETUP, WRITE, WHOLD, DONE} state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt;
    logic [SRAM_AW:0] addr_q;
    logic [7:0]       data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        case (state)
            IDLE:    state_nx = wr ? WSETUP : rd ? READ : DONE;
            READ:    state_nx = cnt == 4'd0 ? DONE : READ;
            WSETUP:  state_nx = WRITE;
            WRITE:   state_nx = cnt == 4'd0 ? WHOLD : WRITE;
            WHOLD:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        locked     = state == DONE;
        sram_ce_n  = !(state == READ || state == WSETUP || state == WRITE || state == WHOLD);
        sram_oe_n  = state != READ;
        sram_we_n  = state != WRITE;
        sram_dq_oe = state == WSETUP || state == WRITE || state == WHOLD;
        sram_ub_n  = sram_ce_n || !addr_q[0];
        sram_lb_n  = sram_ce_n || addr_q[0];
    end

    assign sram_addr = addr_q[SRAM_AW:1];
    assign sram_dq_o = {data_q, data_q};

    // cnt holds the remaining strobe cycles minus one for the current READ/WRITE phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= 4'd0;
            addr_q <= '0;
            data_q <= 8'd0;
            i_data <= 8'd0;
        end else begin
            if (state == IDLE && (rd || wr)) begin
                addr_q <= address[SRAM_AW:0];
                cnt    <= wr ? 4'(WAIT_WR - 1) : 4'(WAIT_RD - 1);
            end else if ((state == READ || state == WRITE) && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == IDLE && wr) data_q <= o_data;
            if (state == READ && cnt == 4'd0) i_data <= addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
        end
    end
endmodule

// File: tb/tb_x86_sram_responder.sv
// tb_x86_sram_responder: random and directed requests checked each cycle against a per-access timeline model.
module tb_x86_sram_responder;
    localparam int AW = 18;
    localparam int WAIT_RD = 2;
    localparam int WAIT_WR = 2;

    logic          clock = 0, reset = 1;
    logic [19:0]   address = 0;
    logic [7:0]    o_data = 0;
    logic          rd = 0, wr = 0;
    logic [7:0]    i_data;
    logic          locked;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_i, sram_dq_o;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    x86_sram_responder #(.SRAM_AW(AW), .WAIT_RD(WAIT_RD), .WAIT_WR(WAIT_WR)) dut (
        .clock(clock), .reset(reset), .address(address), .o_data(o_data), .rd(rd), .wr(wr),
        .i_data(i_data), .locked(locked), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM pins model; written by the DUT's strobes
    bit [15:0] mem [0:(1<<AW)-1];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
    always @(posedge clock) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
        end
    end

    // Reference model: each access is a timeline of m_len cycles after its sampling cycle
    bit [15:0] ref_mem [0:(1<<AW)-1];
    int        m_len = 0, m_k = 0;
    logic      m_r = 0, m_w = 0;
    logic [19:0] m_a = 0;
    logic [7:0]  m_d = 0, e_idata = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_len = 0; m_k = 0; e_idata = 0;
        end else if (m_len == 0) begin
            m_w = wr; m_r = !wr && rd; m_a = address; m_d = o_data;
            m_len = m_w ? WAIT_WR + 3 : m_r ? WAIT_RD + 1 : 1;
            m_k = 1;
        end else if (m_k == m_len) begin
            m_len = 0; m_k = 0;
        end else begin
            m_k++;
            if (m_k == m_len && m_r) e_idata = m_a[0] ? ref_mem[m_a[AW:1]][15:8] : ref_mem[m_a[AW:1]][7:0];
            if (m_k == m_len && m_w) begin
                if (m_a[0]) ref_mem[m_a[AW:1]][15:8] = m_d;
                else ref_mem[m_a[AW:1]][7:0] = m_d;
            end
        end
    end

    logic ea, ed;
    always @(negedge clock) begin
        if (chk_en) begin
            ea = m_len != 0 && m_k < m_len;
            ed = m_len != 0 && m_k == m_len;
            chk("locked", locked, ed);
            chk("ce_n", sram_ce_n, !ea);
            chk("oe_n", sram_oe_n, !(ea && m_r));
            chk("we_n", sram_we_n, !(ea && m_w && m_k >= 2 && m_k <= WAIT_WR + 1));
            chk("dq_oe", sram_dq_oe, ea && m_w);
            chk("ub_n", sram_ub_n, !(ea && m_a[0]));
            chk("lb_n", sram_lb_n, !(ea && !m_a[0]));
            chk("i_data", i_data, e_idata);
            chk("contention", !sram_oe_n && sram_dq_oe, 0);
            if (ea) chk("sram_addr", sram_addr, m_a[AW:1]);
            if (ea && m_w) chk("dq_o", sram_dq_o, {m_d, m_d});
        end
    end

    task automatic run(input logic r, input logic w, input logic [19:0] a, input logic [7:0] d,
                       output int n, output int oc, output int wc,
                       output logic [AW-1:0] sa, output logic [15:0] dq);
        rd = r; wr = w; address = a; o_data = d;
        n = 0; oc = 0; wc = 0; sa = 0; dq = 0;
        do begin
            @(negedge clock);
            n++;
            if (!sram_oe_n) oc++;
            if (!sram_we_n) begin wc++; dq = sram_dq_o; end
            if (!sram_ce_n) sa = sram_addr;
        end while (!locked && n < 40);
        if (!locked) chk("locked_timeout", locked, 1);
    endtask

    int n, oc, wc;
    logic [AW-1:0] sa;
    logic [15:0] dq;
    logic [19:0] ra;
    logic r, w;

    initial begin
        mem[18'h10] = 16'hA55A;  ref_mem[18'h10] = 16'hA55A;
        mem[18'h200] = 16'h7700; ref_mem[18'h200] = 16'h7700;
        mem[18'h0] = 16'h1234;   ref_mem[18'h0] = 16'h1234;
        repeat (3) @(negedge clock);
        chk_en = 1;
        reset = 0;
        run(0, 0, 0, 0, n, oc, wc, sa, dq);
        chk("null_after_reset_lat", n, 1);

        run(1, 0, 20'h00021, 0, n, oc, wc, sa, dq);
        chk("odd_read_lat", n, 4);
        chk("odd_read_oe_cycles", oc, 2);
        chk("odd_read_addr", sa, 18'h10);
        chk("odd_read_data", i_data, 8'hA5);

        rd = 1; wr = 0; address = 20'h00021;
        @(negedge clock);
        @(negedge clock);
        chk("pre_reset_oe", sram_oe_n, 0);
        #2 reset = 1;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_idata", i_data, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_o", sram_dq_o, 0);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        rd = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        run(0, 0, 0, 0, n, oc, wc, sa, dq);
        chk("null_after_reset_lat2", n, 1);

        run(0, 1, 20'h00400, 8'h3C, n, oc, wc, sa, dq);
        chk("even_write_lat", n, 6);
        chk("even_write_we_cycles", wc, 2);
        chk("even_write_dq", dq, 16'h3C3C);
        chk("even_write_addr", sa, 18'h200);
        chk("even_write_mem", mem[18'h200], 16'h773C);

        run(1, 1, 20'h00001, 8'h5E, n, oc, wc, sa, dq);
        chk("rdwr_lat", n, 6);
        chk("rdwr_no_oe", oc, 0);
        chk("rdwr_we_cycles", wc, 2);
        chk("rdwr_mem", mem[18'h0], 16'h5E34);
        run(1, 0, 20'h00001, 0, n, oc, wc, sa, dq);
        chk("readback_data", i_data, 8'h5E);

        for (int i = 0; i < 2; i++) begin
            run(0, 0, 20'h00021, 8'hFF, n, oc, wc, sa, dq);
            chk("null_lat", n, 2);
            chk("null_strobes", oc + wc, 0);
            chk("null_hold_idata", i_data, 8'h5E);
        end

        rd = 0; wr = 1; address = 20'hFFFFF; o_data = 8'h99;
        repeat (3) @(negedge clock);
        chk("wrap_we", sram_we_n, 0);
        chk("wrap_addr", sram_addr, 18'h3FFFF);
        chk("wrap_ub", sram_ub_n, 0);
        chk("wrap_lb", sram_lb_n, 1);
        #2 reset = 1;
        #1;
        chk("rst_write_we", sram_we_n, 1);
        chk("rst_write_ce", sram_ce_n, 1);
        chk("rst_write_dq_oe", sram_dq_oe, 0);
        chk("rst_write_locked", locked, 0);
        wr = 0;
        repeat (3) @(negedge clock);
        reset = 0;
        run(0, 0, 0, 0, n, oc, wc, sa, dq);
        chk("null_after_reset_lat3", n, 1);

        for (int i = 0; i < 300; i++) begin
            ra = 20'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) ra[19:6] = 14'($urandom());
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 2) == 0);
            run(r, w, ra, 8'($urandom()), n, oc, wc, sa, dq);
            chk("rand_lat", n, w ? WAIT_WR + 4 : r ? WAIT_RD + 2 : 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
